// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the true dual-port RAM.
// Holds the default parameters and the clear-sequencer state encoding.
package tdp_ram_pkg;

    localparam int DATA_W_DEF  = 4;
    localparam int ADDR_W_DEF  = 8;
    localparam int OUT_REG_DEF = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

endpackage

// File: rtl/tdp_ram_init.sv
// Clear sequencer: after reset, walks every address once and writes zero.
// Ports: clk, rst_n (sync, active-low); busy, clear_addr, clear_we outputs.
module tdp_ram_init
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              clear_we
);

    init_state_e       state;
    init_state_e       state_next;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        busy       = 1'b0;
        clear_we   = 1'b0;
        unique case (state)
            CLEAR: begin
                busy       = 1'b1;
                clear_we   = 1'b1;
                count_next = count + 1'b1;
                // Last address is being cleared at this edge.
                if (count == {ADDR_W{1'b1}}) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
        endcase
    end

    assign clear_addr = count;

endmodule

// File: rtl/tdp_ram.sv
// True dual-port RAM, read-first, with power-up clear and optional output register.
// Ports: clk, rst_n; per port A/B: chip_selection, write, read, address, data_in,
// data_out, valid; shared busy (clear running) and collision (same-address dual write).
module tdp_ram
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int OUT_REG = OUT_REG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chip_selection_a,
    input  logic              chip_selection_b,
    input  logic              write_a,
    input  logic              write_b,
    input  logic              read_a,
    input  logic              read_b,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_in_a,
    input  logic [DATA_W-1:0] data_in_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              busy,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clear_addr;
    logic              clear_we;

    logic [1:0]             cs;
    logic [1:0]             wr;
    logic [1:0]             rd;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] din;
    logic [1:0][DATA_W-1:0] dout;
    logic [1:0]             vout;

    assign cs   = {chip_selection_b, chip_selection_a};
    assign wr   = {write_b, write_a};
    assign rd   = {read_b, read_a};
    assign addr = {address_b, address_a};
    assign din  = {data_in_b, data_in_a};

    tdp_ram_init #(
        .ADDR_W(ADDR_W)
    ) u_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (busy),
        .clear_addr(clear_addr),
        .clear_we  (clear_we)
    );

    // Port B is written first so port A wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else begin
            if (cs[1] && wr[1]) begin
                mem[addr[1]] <= din[1];
            end
            if (cs[0] && wr[0]) begin
                mem[addr[0]] <= din[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else begin
            collision <= !busy && cs[0] && wr[0] && cs[1] && wr[1]
                         && (addr[0] == addr[1]);
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_W-1:0] d1;
        logic              v1;

        // Nonblocking write above makes this read return pre-edge content.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                d1 <= '0;
                v1 <= 1'b0;
            end else if (busy) begin
                v1 <= 1'b0;
            end else if (!cs[p]) begin
                d1 <= '0;
                v1 <= 1'b0;
            end else if (rd[p]) begin
                d1 <= mem[addr[p]];
                v1 <= 1'b1;
            end else begin
                v1 <= 1'b0;
            end
        end

        if (OUT_REG != 0) begin : g_pipe
            logic [DATA_W-1:0] d2;
            logic              v2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    d2 <= d1;
                    v2 <= v1;
                end
            end

            assign dout[p] = d2;
            assign vout[p] = v2;
        end else begin : g_direct
            assign dout[p] = d1;
            assign vout[p] = v1;
        end
    end

    assign data_out_a = dout[0];
    assign data_out_b = dout[1];
    assign valid_a    = vout[0];
    assign valid_b    = vout[1];

endmodule

// File: tb/tb_tdp_ram.sv
// Self-checking bench for tdp_ram: reference model plus scoreboard queues.
// Directed scenarios followed by randomized dual-port traffic.
module tb_tdp_ram;

    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 8;
    localparam int OUT_REG = 0;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LAT     = 1 + OUT_REG;

    logic              clk;
    logic              rst_n;
    logic              chip_selection_a, chip_selection_b;
    logic              write_a, write_b;
    logic              read_a, read_b;
    logic [ADDR_W-1:0] address_a, address_b;
    logic [DATA_W-1:0] data_in_a, data_in_b;
    logic [DATA_W-1:0] data_out_a, data_out_b;
    logic              valid_a, valid_b;
    logic              busy;
    logic              collision;

    tdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OUT_REG(OUT_REG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .chip_selection_a(chip_selection_a),
        .chip_selection_b(chip_selection_b),
        .write_a         (write_a),
        .write_b         (write_b),
        .read_a          (read_a),
        .read_b          (read_b),
        .address_a       (address_a),
        .address_b       (address_b),
        .data_in_a       (data_in_a),
        .data_in_b       (data_in_b),
        .data_out_a      (data_out_a),
        .data_out_b      (data_out_b),
        .valid_a         (valid_a),
        .valid_b         (valid_b),
        .busy            (busy),
        .collision       (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int   due;
        logic busy;
        logic coll;
    } ctl_t;

    typedef struct {
        int                due;
        logic              va;
        logic [DATA_W-1:0] da;
        logic              vb;
        logic [DATA_W-1:0] db;
    } prt_t;

    ctl_t ctl_q[$];
    prt_t prt_q[$];

    // Reference model: word array, remaining clear cycles, held outputs.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                clear_left;
    logic [DATA_W-1:0] held_a, held_b;
    bit                in_reset = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        clear_left = DEPTH;
        held_a     = '0;
        held_b     = '0;
        ctl_q.delete();
        prt_q.delete();
    endtask

    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n            = 1'b0;
            chip_selection_a = 1'b0;
            chip_selection_b = 1'b0;
            write_a          = 1'b0;
            write_b          = 1'b0;
            read_a           = 1'b0;
            read_b           = 1'b0;
            in_reset         = 1'b1;
            model_reset();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(
        input logic ca, input logic wa, input logic ra,
        input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
        input logic cb, input logic wb, input logic rb,
        input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db
    );
        logic va, vb, coll;
        @(negedge clk);
        rst_n            = 1'b1;
        in_reset         = 1'b0;
        chip_selection_a = ca;
        write_a          = wa;
        read_a           = ra;
        address_a        = aa;
        data_in_a        = da;
        chip_selection_b = cb;
        write_b          = wb;
        read_b           = rb;
        address_b        = ab;
        data_in_b        = db;
        va   = 1'b0;
        vb   = 1'b0;
        coll = 1'b0;
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (!ca) held_a = '0;
            else if (ra) begin
                held_a = ref_mem[aa];
                va     = 1'b1;
            end
            if (!cb) held_b = '0;
            else if (rb) begin
                held_b = ref_mem[ab];
                vb     = 1'b1;
            end
            coll = ca && wa && cb && wb && (aa == ab);
            if (cb && wb) ref_mem[ab] = db;
            if (ca && wa) ref_mem[aa] = da;
        end
        ctl_q.push_back('{due: cyc + 1, busy: (clear_left > 0), coll: coll});
        prt_q.push_back('{due: cyc + LAT, va: va, da: held_a,
                          vb: vb, db: held_b});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic nop();
        drive(1, 0, 0, '0, '0, 1, 0, 0, '0, '0);
    endtask

    task automatic wait_lat();
        repeat (LAT - 1) nop();
    endtask

    task automatic wr_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        drive(1, 1, 0, a, d, 1, 0, 0, '0, '0);
    endtask

    task automatic rd_a(input logic [ADDR_W-1:0] a);
        drive(1, 0, 1, a, '0, 1, 0, 0, '0, '0);
    endtask

    task automatic rd_b(input logic [ADDR_W-1:0] a);
        drive(1, 0, 0, '0, '0, 1, 0, 1, a, '0);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            idle();
            n++;
        end
        check(name, n, DEPTH);
    endtask

    // Monitor: compares every presented output against the scoreboard.
    initial begin
        ctl_t c;
        prt_t p;
        forever begin
            @(posedge clk);
            #1;
            if (in_reset) begin
                check("rst_busy", busy, 1);
                check("rst_coll", collision, 0);
                check("rst_va", valid_a, 0);
                check("rst_vb", valid_b, 0);
                check("rst_da", data_out_a, 0);
                check("rst_db", data_out_b, 0);
            end else begin
                while (ctl_q.size() > 0 && ctl_q[0].due < cyc) begin
                    c = ctl_q.pop_front();
                    check("ctl_missed", c.due, cyc);
                end
                if (ctl_q.size() > 0 && ctl_q[0].due == cyc) begin
                    c = ctl_q.pop_front();
                    check("busy", busy, c.busy);
                    check("collision", collision, c.coll);
                end
                while (prt_q.size() > 0 && prt_q[0].due < cyc) begin
                    p = prt_q.pop_front();
                    check("prt_missed", p.due, cyc);
                end
                if (prt_q.size() > 0 && prt_q[0].due == cyc) begin
                    p = prt_q.pop_front();
                    check("valid_a", valid_a, p.va);
                    check("data_out_a", data_out_a, p.da);
                    check("valid_b", valid_b, p.vb);
                    check("data_out_b", data_out_b, p.db);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        chip_selection_a = 1'b0;
        chip_selection_b = 1'b0;
        write_a          = 1'b0;
        write_b          = 1'b0;
        read_a           = 1'b0;
        read_b           = 1'b0;
        address_a        = '0;
        address_b        = '0;
        data_in_a        = '0;
        data_in_b        = '0;
        model_reset();

        reset_cycles(3);
        count_busy("busy_cycles");

        drive(1, 0, 1, 8'h00, '0, 1, 0, 1, 8'hFF, '0);
        wait_lat();
        check("clr_rd_a", data_out_a, 0);
        check("clr_rd_b", data_out_b, 0);
        check("clr_va", valid_a, 1);

        wr_a(8'h10, 4'hA);
        rd_b(8'h10);
        wait_lat();
        check("wr_then_rd", data_out_b, 4'hA);
        check("wr_then_rd_v", valid_b, 1);

        wr_a(8'h20, 4'h3);
        drive(1, 1, 0, 8'h20, 4'h7, 1, 0, 1, 8'h20, '0);
        wait_lat();
        check("read_first_b", data_out_b, 4'h3);
        rd_b(8'h20);
        wait_lat();
        check("read_after_wr", data_out_b, 4'h7);

        drive(1, 1, 1, 8'h30, 4'h6, 1, 0, 0, '0, '0);
        wait_lat();
        check("same_port_rf", data_out_a, 0);

        drive(1, 1, 0, 8'h40, 4'h5, 1, 1, 0, 8'h40, 4'h9);
        check("coll_pulse", collision, 1);
        nop();
        check("coll_clear", collision, 0);
        rd_a(8'h40);
        wait_lat();
        check("a_wins", data_out_a, 4'h5);
        drive(1, 1, 0, 8'h41, 4'h1, 1, 1, 0, 8'h42, 4'h2);
        check("no_coll_diff", collision, 0);

        wr_a(8'h50, 4'hC);
        rd_a(8'h50);
        wait_lat();
        check("hold_c", data_out_a, 4'hC);
        nop();
        check("hold_c2", data_out_a, 4'hC);
        drive(0, 0, 0, '0, '0, 1, 0, 0, '0, '0);
        wait_lat();
        check("cs_zero_d", data_out_a, 0);
        check("cs_zero_v", valid_a, 0);

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)),
                  DATA_W'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)),
                  DATA_W'($urandom));
        end

        reset_cycles(2);
        repeat (100) idle();
        check("mid_busy", busy, 1);
        reset_cycles(1);
        count_busy("busy_restart");

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, ADDR_W'($urandom),
                  DATA_W'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, ADDR_W'($urandom),
                  DATA_W'($urandom));
        end

        repeat (3) nop();
        check("drain_ctl", ctl_q.size(), 0);
        check("drain_prt", prt_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
